// File: rtl/mnist_pkg.sv
// Shared numeric types for the MNIST inference pipeline.
// Features are signed fixed point; feature_max is the signed compare used by pooling.
package mnist_pkg;

  localparam int unsigned FEATURE_WIDTH = 16;
  localparam int unsigned FEATURE_FRAC  = 8;

  typedef logic signed [FEATURE_WIDTH-1:0] feature_type;

  function automatic feature_type feature_max(input feature_type a, input feature_type b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One row of horizontal pair maxima, written on even rows and read back on odd rows.
// Single address shared by the write port and the asynchronous read port.
module pool_line_buffer
  import mnist_pkg::*;
#(
  parameter int unsigned DEPTH      = 5,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  feature_type           wr_data,
  output feature_type           rd_data
);

  feature_type mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max pool over a raster, channel-major feature stream.
// Output is a single registered slot; upstream is stalled only while that slot is held.
module max_pool_2x2
  import mnist_pkg::*;
#(
  parameter int unsigned IMAGE_HEIGHT = 10,
  parameter int unsigned IMAGE_WIDTH  = 10,
  parameter int unsigned CHANNELS     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  feature_type in_feature,
  input  logic        in_valid,
  output logic        in_ready,
  output feature_type out_feature,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int unsigned CW       = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int unsigned RW       = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned HW       = (CHANNELS     > 1) ? $clog2(CHANNELS)     : 1;
  localparam int unsigned LB_DEPTH = IMAGE_WIDTH / 2;
  localparam int unsigned LB_AW    = (CW > 1) ? CW - 1 : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
  localparam logic [HW-1:0] CHAN_LAST = HW'(CHANNELS - 1);

  if ((IMAGE_HEIGHT % 2) != 0 || (IMAGE_WIDTH % 2) != 0) begin : g_odd_dims
    $error("max_pool_2x2: IMAGE_HEIGHT and IMAGE_WIDTH must both be even");
  end

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [HW-1:0] chan_q, chan_d;
  feature_type   pair_q, pair_d;
  feature_type   out_feature_q, out_feature_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic          accept;
  logic          lb_we;
  logic [LB_AW-1:0] lb_addr;
  feature_type   lb_rd;
  feature_type   pmax;

  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign lb_addr  = LB_AW'(col_q >> 1);
  assign pmax     = feature_max(pair_q, in_feature);

  pool_line_buffer #(
    .DEPTH      (LB_DEPTH),
    .ADDR_WIDTH (LB_AW)
  ) u_line_buffer (
    .clock   (clock),
    .wr_en   (lb_we),
    .addr    (lb_addr),
    .wr_data (pmax),
    .rd_data (lb_rd)
  );

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    chan_d        = chan_q;
    pair_d        = pair_q;
    out_feature_d = out_feature_q;
    out_valid_d   = out_valid_q && !out_ready;
    out_last_d    = out_last_q;
    lb_we         = 1'b0;

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d  = '0;
          chan_d = (chan_q == CHAN_LAST) ? '0 : chan_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!col_q[0]) begin
        pair_d = in_feature;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        // Window complete; accept implies the slot is free or draining this cycle.
        out_feature_d = feature_max(lb_rd, pmax);
        out_valid_d   = 1'b1;
        out_last_d    = (row_q == ROW_LAST) && (col_q == COL_LAST) && (chan_q == CHAN_LAST);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q         <= '0;
      row_q         <= '0;
      chan_q        <= '0;
      out_feature_q <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      chan_q        <= chan_d;
      out_feature_q <= out_feature_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
    end
  end

  always_ff @(posedge clock) begin
    pair_q <= pair_d;
  end

  assign out_feature = out_feature_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: image-array reference model feeds an expected queue,
// an independent monitor pops and compares on every output handshake.
module tb_max_pool_2x2;
  import mnist_pkg::*;

  localparam int H      = 10;
  localparam int W      = 10;
  localparam int C      = 2;
  localparam int BUDGET = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  feature_type in_feature = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  feature_type out_feature;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;

  typedef struct {
    int value;
    bit last;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_out    = 0;
  int unsigned n_last   = 0;
  int unsigned n_stall  = 0;
  int          ready_mode = 1;  // 0: hold off, 1: always ready, 2: random
  bit          gap_mode   = 1'b0;
  int          img [C][H][W];

  max_pool_2x2 #(
    .IMAGE_HEIGHT (H),
    .IMAGE_WIDTH  (W),
    .CHANNELS     (C)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_feature  (in_feature),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_feature (out_feature),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (out_last) n_last++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", int'(out_feature), 32'h7fffffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_feature", int'(out_feature), e.value);
        check("out_last", int'(out_last), int'(e.last));
      end
    end
  end

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic fill_image(input int kind);
    feature_type t;
    for (int ch = 0; ch < C; ch++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          case (kind)
            0: img[ch][r][c] = 10 * r + c + 100 * ch;
            1: img[ch][r][c] = -3 * (1 << FEATURE_FRAC);
            2: img[ch][r][c] = (ch == 1 && r == 5 && c == 8) ? 7 : 0;
            default: begin
              t = feature_type'($urandom);
              img[ch][r][c] = int'(t);
            end
          endcase
        end
  endtask

  task automatic send_beat(input feature_type v);
    int unsigned n = 0;
    if (gap_mode) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    in_valid   = 1'b1;
    in_feature = v;
    @(negedge clock);
    while (!in_ready && n < BUDGET) begin
      n_stall++;
      n++;
      @(negedge clock);
    end
    if (n >= BUDGET) check("in_ready_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int max_beats);
    int   beats = 0;
    exp_t e;
    fill_image(kind);
    for (int ch = 0; ch < C; ch++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          if (beats >= max_beats) return;
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.value = max4(img[ch][r-1][c-1], img[ch][r-1][c], img[ch][r][c-1], img[ch][r][c]);
            e.last  = (ch == C - 1) && (r == H - 1) && (c == W - 1);
            exp_q.push_back(e);
          end
          send_beat(feature_type'(img[ch][r][c]));
          beats++;
        end
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    check("drain_within_budget", int'(n < BUDGET), 1);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_out_feature", int'(out_feature), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_frames(input string name, input int kind, input int frames);
    int unsigned base_out  = n_out;
    int unsigned base_last = n_last;
    for (int f = 0; f < frames; f++) send_frame(kind, H * W * C);
    wait_drain();
    check({name, "_outputs"}, int'(n_out - base_out), frames * (H / 2) * (W / 2) * C);
    check({name, "_lasts"}, int'(n_last - base_last), frames);
  endtask

  initial begin
    int unsigned base_out;
    int unsigned n;

    do_reset();

    ready_mode = 1;
    gap_mode   = 1'b0;
    run_frames("incrementing", 0, 1);
    run_frames("constant_neg3", 1, 1);
    run_frames("single_hot", 2, 1);

    // Backpressure: hold the first output for 20 cycles, then random gaps on both sides.
    ready_mode = 0;
    @(posedge clock);
    #1;
    base_out = n_out;
    fork
      send_frame(0, H * W * C);
      begin
        n = 0;
        @(negedge clock);
        while (!out_valid && n < BUDGET) begin
          @(negedge clock);
          n++;
        end
        check("first_valid_within_budget", int'(n < BUDGET), 1);
        repeat (20) begin
          check("hold_out_feature", int'(out_feature), 11);
          check("hold_out_valid", int'(out_valid), 1);
          check("hold_in_ready", int'(in_ready), 0);
          @(negedge clock);
        end
        ready_mode = 2;
        gap_mode   = 1'b1;
      end
    join
    wait_drain();
    check("backpressure_outputs", int'(n_out - base_out), 50);
    run_frames("random_gaps", 3, 2);

    // Reset mid-frame after 37 accepted beats.
    ready_mode = 1;
    gap_mode   = 1'b0;
    @(posedge clock);
    #1;
    base_out = n_out;
    send_frame(0, 37);
    wait_drain();
    check("partial_frame_outputs", int'(n_out - base_out), 8);
    do_reset();
    run_frames("after_reset", 0, 1);

    // Back-to-back frames with continuous flow must never stall.
    n_stall = 0;
    base_out = n_out;
    send_frame(0, H * W * C);
    send_frame(3, H * W * C);
    wait_drain();
    check("b2b_stalls", int'(n_stall), 0);
    check("b2b_outputs", int'(n_out - base_out), 100);

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
